// File: rtl/votacion_pkg.sv
// Shared definitions for the ballot collector: FSM states, default voter
// count and the absolute-majority helper.
package votacion_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    VOTANDO  = 2'd1,
    RECUENTO = 2'd2,
    PUBLICA  = 2'd3
  } estado_t;

  localparam int unsigned N_VOTANTES_DEF = 3;

  // Majority is measured against the full electorate, not the votes cast.
  function automatic logic mayoria(input int unsigned si, input int unsigned n);
    return (2 * si) > n;
  endfunction

endpackage

// File: rtl/registro_emitidos.sv
// Bitmap of voters that have already cast a ballot in the current session.
module registro_emitidos
  import votacion_pkg::*;
#(
  parameter int unsigned N_VOTANTES = N_VOTANTES_DEF,
  parameter int unsigned W_ID       = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            limpiar,
  input  logic            marcar,
  input  logic [W_ID-1:0] id,
  output logic            ya_voto
);

  logic [N_VOTANTES-1:0] emitido;
  logic [2**W_ID-1:0]    emitido_ext;
  logic                  en_rango;

  assign en_rango = 32'(id) < N_VOTANTES;

  // Widened copy so an out-of-range id indexes a defined zero bit.
  always_comb begin
    emitido_ext                 = '0;
    emitido_ext[N_VOTANTES-1:0] = emitido;
  end

  assign ya_voto = emitido_ext[id] & en_rango;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emitido <= '0;
    end else if (limpiar) begin
      emitido <= '0;
    end else if (marcar) begin
      for (int unsigned i = 0; i < N_VOTANTES; i++) begin
        if (id == W_ID'(i)) emitido[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/urna_votacion.sv
// Sequential ballot collector: accepts one vote per cycle per voter id and
// publishes an absolute-majority decision with counts when the session closes.
module urna_votacion
  import votacion_pkg::*;
#(
  parameter int unsigned N_VOTANTES = N_VOTANTES_DEF,
  parameter int unsigned W_ID       = 2,
  parameter int unsigned W_CNT      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abrir,
  input  logic             cerrar,
  input  logic             voto_valido,
  input  logic             voto,
  input  logic [W_ID-1:0]  id,
  output logic             listo,
  output logic             rechazado,
  output logic [W_CNT-1:0] cuenta_si,
  output logic [W_CNT-1:0] cuenta_no,
  output logic             resultado,
  output logic             empate,
  output logic             resultado_valido
);

  estado_t        estado, estado_sig;
  logic           ya_voto;
  logic           en_rango;
  logic           aceptado;
  logic           abrir_ok;
  logic [W_CNT:0] total_sig;

  assign listo            = (estado == VOTANDO);
  assign resultado_valido = (estado == PUBLICA);
  assign abrir_ok         = (estado == REPOSO) && abrir;
  assign en_rango         = 32'(id) < N_VOTANTES;
  assign aceptado         = voto_valido && listo && en_rango && !ya_voto;
  assign total_sig        = {1'b0, cuenta_si} + {1'b0, cuenta_no} + (W_CNT+1)'(aceptado);

  registro_emitidos #(
    .N_VOTANTES (N_VOTANTES),
    .W_ID       (W_ID)
  ) u_registro (
    .clk     (clk),
    .reset_n (reset_n),
    .limpiar (abrir_ok),
    .marcar  (aceptado),
    .id      (id),
    .ya_voto (ya_voto)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= REPOSO;
    else          estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      REPOSO:   if (abrir) estado_sig = VOTANDO;
      VOTANDO:  if (cerrar || (aceptado && total_sig == (W_CNT+1)'(N_VOTANTES)))
                  estado_sig = RECUENTO;
      RECUENTO: estado_sig = PUBLICA;
      PUBLICA:  estado_sig = REPOSO;
      default:  estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cuenta_si <= '0;
      cuenta_no <= '0;
      resultado <= 1'b0;
      empate    <= 1'b0;
      rechazado <= 1'b0;
    end else begin
      rechazado <= listo && voto_valido && !aceptado;
      if (abrir_ok) begin
        cuenta_si <= '0;
        cuenta_no <= '0;
        resultado <= 1'b0;
        empate    <= 1'b0;
      end else if (aceptado) begin
        if (voto) cuenta_si <= cuenta_si + 1'b1;
        else      cuenta_no <= cuenta_no + 1'b1;
      end else if (estado == RECUENTO) begin
        resultado <= mayoria(32'(cuenta_si), N_VOTANTES);
        empate    <= (cuenta_si == cuenta_no);
      end
    end
  end

endmodule

// File: doc/urna_votacion.md
Name: urna_votacion

Overview:
- Sequential ballot collector: the clocked counterpart to the team's combinational majority voters.
- Votes arrive one per cycle over a valid/ready handshake, tagged with a voter id.
- Duplicates and invalid ids are rejected.
- On close, the block publishes an absolute-majority decision plus counts.
- Sits between voter-input front ends and any consumer of the decision.

Parameters:
- N_VOTANTES, 3, number of voters; legal range 2..15.
- W_ID, 2, voter id width; must satisfy 2^W_ID ≥ N_VOTANTES.
- W_CNT, 2, counter width; must satisfy 2^W_CNT > N_VOTANTES.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- abrir  input  1  open a session; sampled only in REPOSO.
- cerrar  input  1  force-close the session; sampled only in VOTANDO.
- voto_valido  input  1  vote offered this cycle.
- voto  input  1  vote value; 1 = yes, 0 = no.
- id  input  W_ID  voter identifier.
- listo  output  1  ready; high exactly while the state is VOTANDO.
- rechazado  output  1  1-cycle pulse the cycle after a rejected vote.
- cuenta_si  output  W_CNT  accepted yes votes.
- cuenta_no  output  W_CNT  accepted no votes.
- resultado  output  1  1 iff 2*cuenta_si > N_VOTANTES.
- empate  output  1  1 iff cuenta_si == cuenta_no.
- resultado_valido  output  1  1-cycle publication pulse.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state = REPOSO.
  - all outputs = 0.
  - counters = 0.
  - emitido[N_VOTANTES-1:0] bitmap = 0.
  - Reset mid-session discards the session entirely; no result is published.
- States: REPOSO → VOTANDO → RECUENTO → PUBLICA → REPOSO.
- REPOSO:
  - listo = 0.
  - Previous resultado, empate and counts hold.
  - abrir=1 → next edge: clear counts, emitido, resultado and empate; go to VOTANDO.
- VOTANDO:
  - listo = 1.
  - A vote is accepted when voto_valido & listo & (id < N_VOTANTES) & !emitido[id].
  - On accept: set emitido[id]; increment cuenta_si or cuenta_no per voto.
  - If voto_valido=1 but the vote is not accepted: no count change; rechazado=1 in the next cycle.
  - Transition to RECUENTO on the edge where either:
    - the vote accepted that edge makes cuenta_si + cuenta_no == N_VOTANTES, or
    - cerrar=1.
  - cerrar together with a valid vote in the same cycle: the vote is evaluated and counted first, then the session closes.
  - abrir is ignored.
- RECUENTO (1 cycle):
  - listo = 0; incoming votes are ignored and are not flagged rechazado.
  - resultado and empate are registered from the final counts.
  - Always go to PUBLICA.
- PUBLICA (1 cycle):
  - resultado_valido = 1.
  - Always go to REPOSO.
  - abrir during PUBLICA is ignored.
- Latency: session-closing edge k → RECUENTO during cycle k+1 → resultado_valido high during cycle k+2.
- Arithmetic:
  - Counters never wrap, because each id can be counted at most once.
  - Comparisons use W_CNT+1 bits.
  - Absent voters count as neither yes nor no; a majority requires more than half of N_VOTANTES, not half of the votes cast.
- Empty session (cerrar with zero votes): resultado=0, empate=1, counts 0, pulse still emitted.
- Simultaneous abrir and cerrar while in REPOSO: open only.

Decomposition:
- Shared package/header votacion_pkg:
  - state encodings REPOSO=2'd0, VOTANDO=2'd1, RECUENTO=2'd2, PUBLICA=2'd3;
  - default N_VOTANTES;
  - helper function for majority (2*si > n).
- One natural sub-module: registro_emitidos.
  - N_VOTANTES-bit bitmap with synchronous clear.
  - Set by id on accept.
  - Combinational output `ya_voto` = emitido[id] & (id < N).
- FSM, counters and result registers live in urna_votacion.

Test Plan:
- Reset, then abrir; votes id0=1, id1=1, id2=0 → listo falls after the 3rd vote; resultado_valido pulses 2 cycles later; resultado=1, cuenta_si=2, cuenta_no=1, empate=0.
- Votes id0=1, then id0=0 again, then id3 (N=3) → both later votes give a rechazado pulse; cuenta_si=1, cuenta_no=0.
- abrir, vote id1=0, cerrar → resultado=0, cuenta_no=1, empate=0; pulse 2 cycles after cerrar.
- abrir then immediate cerrar with no votes → resultado=0, empate=1, counts 0.
- cerrar and vote id2=1 in the same cycle → vote counted (cuenta_si incremented), then close.
- reset_n pulled low mid-session after 2 votes → outputs 0 immediately (asynchronous); no resultado_valido; a new abrir starts from 0.
